// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared constants, FSM state encoding and GF(2^8) helper for the AES-128
//   key-schedule controller and its round-step datapath.
//   Contents:
//     KEY_W      key / round-key width (128)
//     NR         number of expansion rounds (10)
//     RCON_INIT  first round constant
//     RCON_POLY  reduction byte applied when xtime overflows
//     keySchedStateT  controller states IDLE / EXPAND / FINISH
//     xtime()    multiply a byte by x in GF(2^8)
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int NR    = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    FINISH = 2'd2
  } keySchedStateT;

  // Doubling in GF(2^8): shift left and fold the carried-out bit back in
  // with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl_if
//   Bundles the key-source handshake and the round-key read port of the
//   key-schedule controller.
//   Signals:
//     start       key source -> ctrl   start pulse
//     key_in      key source -> ctrl   128-bit cipher key
//     busy        ctrl -> key source   expansion in progress
//     done        ctrl -> key source   one-cycle completion pulse
//     keys_valid  ctrl -> readers      buffer holds a complete schedule
//     rd_idx      readers -> ctrl      round-key index 0..10
//     rd_key      ctrl -> readers      round key at rd_idx (0 when invalid)
//   Modports:
//     master  key source / round-key reader side
//     slave   controller side
// ---------------------------------------------------------------------------
interface aes_key_sched_ctrl_if;
  import aes_pkg::*;

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic             busy;
  logic             done;
  logic             keys_valid;
  logic [3:0]       rd_idx;
  logic [KEY_W-1:0] rd_key;

  modport master (
    output start, key_in, rd_idx,
    input  busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, key_in, rd_idx,
    output busy, done, keys_valid, rd_key
  );

endinterface

// File: rtl/aes_key_round_step.sv
// ---------------------------------------------------------------------------
// aes_key_round_step
//   One combinational AES-128 key-expansion step: derives round key r+1
//   from round key r and the round constant for round r+1.
//   Ports:
//     curKey  in  128  current round key, w0 = [127:96] .. w3 = [31:0]
//     rcon    in  8    round constant XORed into the top byte
//     nxtKey  out 128  next round key
// ---------------------------------------------------------------------------
module aes_key_round_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] curKey,
  input  logic [7:0]       rcon,
  output logic [KEY_W-1:0] nxtKey
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rotWord, subWord, tempWord;
  logic [31:0] w0n, w1n, w2n, w3n;

  // RotWord moves the top byte of w3 to the bottom, SubWord runs each byte
  // through the S-box, then the round constant lands on the top byte.
  // The new words chain left to right, each folding in its neighbour.
  always_comb begin
    w0 = curKey[127:96];
    w1 = curKey[95:64];
    w2 = curKey[63:32];
    w3 = curKey[31:0];

    rotWord  = {w3[23:0], w3[31:24]};
    subWord  = {SBOX[rotWord[31:24]], SBOX[rotWord[23:16]],
                SBOX[rotWord[15:8]],  SBOX[rotWord[7:0]]};
    tempWord = subWord ^ {rcon, 24'h000000};

    w0n = w0 ^ tempWord;
    w1n = w1 ^ w0n;
    w2n = w2 ^ w1n;
    w3n = w3 ^ w2n;

    nxtKey = {w0n, w1n, w2n, w3n};
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
//   Iterative AES-128 key-expansion controller. On an accepted start it
//   stores the cipher key as round key 0, then produces one round key per
//   clock for rounds 1..10 into an 11-entry buffer that the round datapaths
//   read by index.
//   Ports:
//     clk    in  1   clock, rising edge
//     rst_n  in  1   asynchronous active-low reset
//     bus    slave modport of aes_key_sched_ctrl_if
//              start/key_in  : start pulse and cipher key (IDLE only)
//              busy/done     : expansion running / one-cycle completion
//              keys_valid    : complete schedule available
//              rd_idx/rd_key : combinational round-key read
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  aes_key_sched_ctrl_if.slave  bus
);

  keySchedStateT    state, nextState;
  logic             busyQ, doneQ, validQ;
  logic             nextBusy, nextDone, nextValid;
  logic             acceptKey, stepEn, lastStep;

  logic [3:0]       round;
  logic [7:0]       rcon;
  logic [KEY_W-1:0] curKey;
  logic [KEY_W-1:0] stepKey;
  logic [KEY_W-1:0] keyBuf [0:NR];

  aes_key_round_step uStep (
    .curKey (curKey),
    .rcon   (rcon),
    .nxtKey (stepKey)
  );

  // State register plus the registered status flags. Done, busy and
  // keys_valid all change on the edge that writes round key 10, so done is
  // visible during the single FINISH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      validQ <= 1'b0;
    end else begin
      state  <= nextState;
      busyQ  <= nextBusy;
      doneQ  <= nextDone;
      validQ <= nextValid;
    end
  end

  // Next-state and control decode. Start is only looked at in IDLE, so a
  // pulse during EXPAND or FINISH is simply dropped. Accepting a new key
  // invalidates the old schedule straight away.
  always_comb begin
    nextState = state;
    nextBusy  = busyQ;
    nextDone  = 1'b0;
    nextValid = validQ;
    acceptKey = 1'b0;
    stepEn    = 1'b0;
    lastStep  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acceptKey = 1'b1;
          nextBusy  = 1'b1;
          nextValid = 1'b0;
          nextState = EXPAND;
        end
      end
      EXPAND: begin
        stepEn = 1'b1;
        if (round == 4'(NR)) begin
          lastStep  = 1'b1;
          nextBusy  = 1'b0;
          nextDone  = 1'b1;
          nextValid = 1'b1;
          nextState = FINISH;
        end
      end
      FINISH: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Expansion working registers. The round counter stays at 10 after the
  // last step rather than wrapping; it is reloaded on the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round  <= 4'd0;
      rcon   <= RCON_INIT;
      curKey <= '0;
    end else if (acceptKey) begin
      round  <= 4'd1;
      rcon   <= RCON_INIT;
      curKey <= bus.key_in;
    end else if (stepEn) begin
      rcon   <= xtime(rcon);
      curKey <= stepKey;
      if (!lastStep) begin
        round <= round + 4'd1;
      end
    end
  end

  // Round-key buffer. It carries no reset: its contents are only exposed
  // while keys_valid is high, which requires a full expansion since reset.
  always_ff @(posedge clk) begin
    if (acceptKey) begin
      keyBuf[0] <= bus.key_in;
    end else if (stepEn) begin
      keyBuf[round] <= stepKey;
    end
  end

  assign bus.busy       = busyQ;
  assign bus.done       = doneQ;
  assign bus.keys_valid = validQ;
  assign bus.rd_key     = (validQ && (bus.rd_idx <= 4'(NR))) ? keyBuf[bus.rd_idx] : '0;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
//   Self-checking bench for aes_key_sched_ctrl. Expected round keys are
//   queued when a start is driven and compared once the schedule completes.
// ---------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ALT_KEY  = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } sbEntryT;

  logic clk;
  logic rst_n;
  int   errorCount;
  int   checkCount;
  int   lat;
  sbEntryT sbQ [$];

  aes_key_sched_ctrl_if bus ();

  aes_key_sched_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic pushEntry(input logic [3:0] idx, input logic [127:0] key);
    sbEntryT e;
    e.idx = idx;
    e.key = key;
    sbQ.push_back(e);
  endtask

  // Called at a negedge. Holds start for one cycle, queues the expected
  // schedule, then scrambles key_in so a late sample would be caught.
  task automatic applyStimulus(input logic [127:0] key, input bit expectSched);
    bus.key_in = key;
    bus.start  = 1'b1;
    if (expectSched) begin
      if (key == FIPS_KEY) begin
        pushEntry(4'd0,  FIPS_KEY);
        pushEntry(4'd1,  FIPS_R1);
        pushEntry(4'd10, FIPS_R10);
      end else begin
        pushEntry(4'd0,  ZERO_KEY);
        pushEntry(4'd1,  ZERO_R1);
        pushEntry(4'd10, ZERO_R10);
      end
      pushEntry(4'd11, 128'h0);
      pushEntry(4'd15, 128'h0);
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.key_in = ~key;
  endtask

  // Entered at the negedge of cycle T+1. Optionally pulses start with a
  // different key in cycles T+3 and T+11. Returns at the negedge of T+12.
  task automatic waitDone(input bit disturb, output int latency);
    int n;
    n = 1;
    latency = -1;
    bus.rd_idx = 4'd1;
    while (n <= 40) begin
      if (disturb && (n == 3 || n == 11)) begin
        bus.start  = 1'b1;
        bus.key_in = ALT_KEY;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (n == 1) begin
        checkOutput("busyAfterAccept", 128'(bus.busy), 128'(1));
        checkOutput("validDropped", 128'(bus.keys_valid), 128'(0));
      end
      if (n == 5) checkOutput("rdKeyDuringExpand", bus.rd_key, 128'h0);
      if (n == 10) checkOutput("busyLastStep", 128'(bus.busy), 128'(1));
      if (bus.done) begin
        latency = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    checkOutput("doneLatency", 128'(latency), 128'(11));
    checkOutput("busyAtDone", 128'(bus.busy), 128'(0));
    checkOutput("validAtDone", 128'(bus.keys_valid), 128'(1));
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    checkOutput("donePulseEnds", 128'(bus.done), 128'(0));
    checkOutput("validHeld", 128'(bus.keys_valid), 128'(1));
  endtask

  // Pops every queued expectation and compares the combinational read port.
  task automatic drainScoreboard();
    sbEntryT e;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      bus.rd_idx = e.idx;
      #1;
      checkOutput($sformatf("rdKey[%0d]", e.idx), bus.rd_key, e.key);
    end
    @(negedge clk);
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.key_in = '0;
    bus.rd_idx = 4'd0;

    repeat (2) @(negedge clk);
    checkOutput("resetBusy", 128'(bus.busy), 128'(0));
    checkOutput("resetDone", 128'(bus.done), 128'(0));
    checkOutput("resetValid", 128'(bus.keys_valid), 128'(0));
    checkOutput("resetRdKey", bus.rd_key, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] FIPS-197 key schedule");
    applyStimulus(FIPS_KEY, 1'b1);
    waitDone(1'b0, lat);
    drainScoreboard();

    $display("[TB] all-zero key schedule");
    applyStimulus(ZERO_KEY, 1'b1);
    waitDone(1'b0, lat);
    drainScoreboard();

    $display("[TB] start pulses during expansion are ignored");
    applyStimulus(FIPS_KEY, 1'b1);
    waitDone(1'b1, lat);
    drainScoreboard();

    $display("[TB] reset in the middle of an expansion");
    applyStimulus(ZERO_KEY, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    bus.rd_idx = 4'd0;
    #1;
    checkOutput("abortBusy", 128'(bus.busy), 128'(0));
    checkOutput("abortValid", 128'(bus.keys_valid), 128'(0));
    checkOutput("abortRdKey", bus.rd_key, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(FIPS_KEY, 1'b1);
    waitDone(1'b0, lat);
    drainScoreboard();

    $display("[TB] back-to-back schedules");
    applyStimulus(FIPS_KEY, 1'b0);
    waitDone(1'b0, lat);
    applyStimulus(ZERO_KEY, 1'b1);
    pushEntry(4'd12, 128'h0);
    pushEntry(4'd13, 128'h0);
    pushEntry(4'd14, 128'h0);
    waitDone(1'b0, lat);
    drainScoreboard();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
